// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI target block.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    DONE
  } state_t;

  localparam int unsigned DATA_W_DEF = 8;

  // Word shifted out when the master clocks a word with no TX data loaded.
  localparam logic [DATA_W_DEF-1:0] UNDERRUN_FILL = 8'h00;

endpackage

// File: rtl/spi_slave_if.sv
// SPI pins plus local byte valid/ready interface of the SPI target.
// cpol/cpha exist only when SPI_SLAVE_MODE_SEL_EN is defined.
interface spi_slave_if
  import spi_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
);

  logic              sck;
  logic              ss;
  logic              mosi;
  logic              miso;
  logic              miso_oe;
`ifdef SPI_SLAVE_MODE_SEL_EN
  logic              cpol;
  logic              cpha;
`endif
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              busy;
  logic              overrun;

  modport slave (
`ifdef SPI_SLAVE_MODE_SEL_EN
    input  cpol, cpha,
`endif
    input  sck, ss, mosi, tx_data, tx_valid, rx_ready,
    output miso, miso_oe, tx_ready, rx_data, rx_valid, busy, overrun
  );

  modport master (
`ifdef SPI_SLAVE_MODE_SEL_EN
    output cpol, cpha,
`endif
    output sck, ss, mosi, tx_data, tx_valid, rx_ready,
    input  miso, miso_oe, tx_ready, rx_data, rx_valid, busy, overrun
  );

endinterface

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for one async pin with rise/fall pulses decoded
// from the last two synchronised samples.
module spi_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise,
  output logic fall
);

  // chain[SYNC_STAGES-1] is the synchronised level, chain[SYNC_STAGES] its previous sample.
  logic [SYNC_STAGES:0] chain;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) chain <= {(SYNC_STAGES + 1){RST_VAL}};
    else      chain <= {chain[SYNC_STAGES-1:0], din};
  end

  always_comb begin
    rise = chain[SYNC_STAGES-1] & ~chain[SYNC_STAGES];
    fall = ~chain[SYNC_STAGES-1] & chain[SYNC_STAGES];
  end

endmodule

// File: rtl/spi_slave.sv
// SPI target: oversampled sck/ss/mosi, MSB-first shift, TX holding register,
// RX valid/ready with sticky overrun. SPI_SLAVE_MODE_SEL_EN adds cpol/cpha.
module spi_slave
  import spi_pkg::*;
#(
  parameter int unsigned DATA_W      = DATA_W_DEF,
  parameter int unsigned SYNC_STAGES = 2
) (
  input logic        clk,
  input logic        rst,
  spi_slave_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(DATA_W + 1);

  state_t              state, state_nxt;
  logic                sck_rise, sck_fall, ss_rise, ss_fall;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                mosi_s;
  logic                sample_edge, shift_edge, drive_on_select;
  logic [DATA_W-1:0]   shift_q, hold_q, rx_data_q, reload;
  logic                hold_full, rx_valid_q, overrun_q, miso_q;
  logic [CNT_W-1:0]    bit_cnt;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (bus.sck),
    .rise (sck_rise),
    .fall (sck_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ss_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (bus.ss),
    .rise (ss_rise),
    .fall (ss_fall)
  );

  // Same depth as the sck path so the sampled bit lines up with the sck edge pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) mosi_sync <= '0;
    else      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.mosi};
  end
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

`ifdef SPI_SLAVE_MODE_SEL_EN
  logic cpol_q, cpha_q, lead_edge, trail_edge;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cpol_q <= 1'b0;
      cpha_q <= 1'b0;
    end else if (state == IDLE) begin
      cpol_q <= bus.cpol;
      cpha_q <= bus.cpha;
    end
  end

  always_comb begin
    lead_edge       = cpol_q ? sck_fall : sck_rise;
    trail_edge      = cpol_q ? sck_rise : sck_fall;
    sample_edge     = cpha_q ? trail_edge : lead_edge;
    shift_edge      = cpha_q ? lead_edge : trail_edge;
    drive_on_select = ~bus.cpha;
  end
`else
  always_comb begin
    sample_edge     = sck_rise;
    shift_edge      = sck_fall;
    drive_on_select = 1'b1;
  end
`endif

  assign reload = hold_full ? hold_q : DATA_W'(UNDERRUN_FILL);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (ss_fall) state_nxt = ACTIVE;
      ACTIVE:  if (sample_edge && bit_cnt == CNT_W'(DATA_W - 1)) state_nxt = DONE;
      DONE:    state_nxt = ACTIVE;
      default: state_nxt = IDLE;
    endcase
    if (ss_rise) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_q    <= '0;
      hold_q     <= '0;
      hold_full  <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
      miso_q     <= 1'b0;
      bit_cnt    <= '0;
    end else begin
      if (bus.tx_valid && !hold_full) begin
        hold_q    <= bus.tx_data;
        hold_full <= 1'b1;
      end
      if (rx_valid_q && bus.rx_ready) rx_valid_q <= 1'b0;

      if (ss_rise) begin
        bit_cnt <= '0;
        miso_q  <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (ss_fall) begin
              shift_q <= reload;
              if (hold_full) hold_full <= 1'b0;
              bit_cnt <= '0;
              miso_q  <= drive_on_select & reload[DATA_W-1];
            end
          end
          ACTIVE: begin
            if (sample_edge) begin
              shift_q <= {shift_q[DATA_W-2:0], mosi_s};
              bit_cnt <= bit_cnt + 1'b1;
            end else if (shift_edge) begin
              miso_q <= shift_q[DATA_W-1];
            end
          end
          DONE: begin
            // A pending word not accepted this clk wins; a same-clk accept frees the slot.
            if (rx_valid_q && !bus.rx_ready) begin
              overrun_q <= 1'b1;
            end else begin
              rx_data_q  <= shift_q;
              rx_valid_q <= 1'b1;
            end
            shift_q <= reload;
            if (hold_full) hold_full <= 1'b0;
            bit_cnt <= '0;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.miso     = miso_q;
  assign bus.busy     = (state != IDLE);
  assign bus.miso_oe  = (state != IDLE);
  assign bus.tx_ready = ~hold_full;
  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;
  assign bus.overrun  = overrun_q;

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave in mode 0: acts as SPI master and local byte user.
module tb_spi_slave;

  localparam int unsigned H = 5;  // clk cycles per sck half period

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [7:0] rx_q[$];
  int         txr_low_cnt = 0;

  spi_slave_if #(.DATA_W(8)) bus ();

  spi_slave #(.DATA_W(8), .SYNC_STAGES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.rx_valid && bus.rx_ready) rx_q.push_back(bus.rx_data);
    if (!bus.tx_ready) txr_low_cnt++;
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
    end
  endtask

  task automatic spi_xfer(input int unsigned nbits, input logic [7:0] tx, output logic [7:0] rx);
    rx = '0;
    for (int unsigned i = 0; i < nbits; i++) begin
      bus.mosi = tx[7-i];
      repeat (H) @(negedge clk);
      rx = {rx[6:0], bus.miso};
      bus.sck = 1'b1;
      repeat (H) @(negedge clk);
      bus.sck = 1'b0;
    end
  endtask

  task automatic ss_low();
    @(negedge clk);
    bus.ss = 1'b0;
  endtask

  task automatic ss_high();
    repeat (H) @(negedge clk);
    bus.ss = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic load_tx(input logic [7:0] d);
    int unsigned n = 0;
    @(negedge clk);
    while (!bus.tx_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!bus.tx_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL load_tx timeout: tx_ready=%b expected 1", bus.tx_ready);
    end
    bus.tx_data  = d;
    bus.tx_valid = 1'b1;
    @(negedge clk);
    bus.tx_valid = 1'b0;
  endtask

  task automatic wait_rx_valid();
    int unsigned n = 0;
    while (!bus.rx_valid && n < 60) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic accept_rx();
    @(negedge clk);
    bus.rx_ready = 1'b1;
    @(negedge clk);
    bus.rx_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, " miso"},     {7'd0, bus.miso},     8'h00);
    chk({tag, " miso_oe"},  {7'd0, bus.miso_oe},  8'h00);
    chk({tag, " tx_ready"}, {7'd0, bus.tx_ready}, 8'h01);
    chk({tag, " rx_data"},  bus.rx_data,          8'h00);
    chk({tag, " rx_valid"}, {7'd0, bus.rx_valid}, 8'h00);
    chk({tag, " busy"},     {7'd0, bus.busy},     8'h00);
    chk({tag, " overrun"},  {7'd0, bus.overrun},  8'h00);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_basic();
    logic [7:0] got;
    load_tx(8'hA5);
    chk("basic tx_ready after load", {7'd0, bus.tx_ready}, 8'h00);
    ss_low();
    repeat (4) @(negedge clk);
    chk("basic busy", {7'd0, bus.busy}, 8'h01);
    chk("basic miso_oe", {7'd0, bus.miso_oe}, 8'h01);
    spi_xfer(8, 8'h3C, got);
    chk("basic master rx", got, 8'hA5);
    ss_high();
    chk("basic busy after ss", {7'd0, bus.busy}, 8'h00);
    wait_rx_valid();
    chk("basic rx_valid", {7'd0, bus.rx_valid}, 8'h01);
    chk("basic rx_data", bus.rx_data, 8'h3C);
    accept_rx();
    chk("basic rx_valid after accept", {7'd0, bus.rx_valid}, 8'h00);
  endtask

  task automatic test_back_to_back();
    logic [7:0] got0, got1;
    int         start;
    bus.rx_ready = 1'b1;
    start = rx_q.size();
    load_tx(8'h11);
    ss_low();
    load_tx(8'h22);
    spi_xfer(8, 8'h80, got0);
    spi_xfer(8, 8'h01, got1);
    ss_high();
    bus.rx_ready = 1'b0;
    chk("b2b master rx word0", got0, 8'h11);
    chk("b2b master rx word1", got1, 8'h22);
    chk("b2b rx word count", 8'(rx_q.size() - start), 8'd2);
    if (rx_q.size() - start == 2) begin
      chk("b2b rx word0", rx_q[start], 8'h80);
      chk("b2b rx word1", rx_q[start+1], 8'h01);
    end
  endtask

  task automatic test_overrun();
    logic [7:0] got;
    ss_low();
    spi_xfer(8, 8'h55, got);
    spi_xfer(8, 8'hAA, got);
    ss_high();
    wait_rx_valid();
    chk("ovr rx_valid", {7'd0, bus.rx_valid}, 8'h01);
    chk("ovr rx_data kept", bus.rx_data, 8'h55);
    chk("ovr overrun", {7'd0, bus.overrun}, 8'h01);
    accept_rx();
    chk("ovr rx_valid after accept", {7'd0, bus.rx_valid}, 8'h00);
    chk("ovr overrun sticky", {7'd0, bus.overrun}, 8'h01);
  endtask

  task automatic test_abort();
    logic [7:0] got;
    ss_low();
    spi_xfer(5, 8'hFF, got);
    ss_high();
    repeat (10) @(negedge clk);
    chk("abort rx_valid", {7'd0, bus.rx_valid}, 8'h00);
    chk("abort busy", {7'd0, bus.busy}, 8'h00);
    ss_low();
    spi_xfer(8, 8'h0F, got);
    ss_high();
    wait_rx_valid();
    chk("abort next rx_valid", {7'd0, bus.rx_valid}, 8'h01);
    chk("abort next rx_data", bus.rx_data, 8'h0F);
    accept_rx();
  endtask

  task automatic test_underrun();
    logic [7:0] got;
    int         low_before;
    chk("underrun tx_ready idle", {7'd0, bus.tx_ready}, 8'h01);
    low_before = txr_low_cnt;
    ss_low();
    spi_xfer(8, 8'h5A, got);
    ss_high();
    chk("underrun master rx", got, 8'h00);
    chk("underrun tx_ready low clks", 8'(txr_low_cnt - low_before), 8'd0);
    wait_rx_valid();
    chk("underrun rx_data", bus.rx_data, 8'h5A);
  endtask

  task automatic test_reset_midframe();
    logic [7:0] got;
    ss_low();
    load_tx(8'h99);
    spi_xfer(3, 8'hE0, got);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_reset_vals("midrst");
    bus.ss  = 1'b1;
    bus.sck = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    load_tx(8'hC3);
    ss_low();
    spi_xfer(8, 8'hC3, got);
    ss_high();
    chk("midrst master rx", got, 8'hC3);
    wait_rx_valid();
    chk("midrst rx_data", bus.rx_data, 8'hC3);
  endtask

  initial begin
    rst          = 1'b0;
    bus.sck      = 1'b0;
    bus.ss       = 1'b1;
    bus.mosi     = 1'b0;
    bus.tx_data  = '0;
    bus.tx_valid = 1'b0;
    bus.rx_ready = 1'b0;
`ifdef SPI_SLAVE_MODE_SEL_EN
    bus.cpol     = 1'b0;
    bus.cpha     = 1'b0;
`endif
    test_reset();
    test_basic();
    test_back_to_back();
    test_overrun();
    test_abort();
    test_underrun();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
